// File: rtl/c64_bus_pkg.sv
// Shared types and constants for the C64 expansion-port DMA master.
package c64_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_ACCESS,
    ST_HOLD,
    ST_RELEASE
  } state_t;

  localparam int SETTLE_PHI2_DEF  = 3;
  localparam int SAMPLE_DELAY_DEF = 20;
  localparam int HOLD_PHI2_DEF    = 4;

  // Width of all internal counters; every counter saturates at all-ones.
  localparam int CNT_W = 8;

  // C64 R/W line levels and the request-side rw encoding.
  localparam logic RW_READ   = 1'b1;
  localparam logic RW_WRITE  = 1'b0;
  localparam logic REQ_WRITE = 1'b1;

endpackage

// File: rtl/phi2_sync.sv
// Two-flop synchronisers for the asynchronous C64 phi2 and BA lines,
// plus one-clk rise/fall pulses derived from the synchronised phi2.
module phi2_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic phi2,
  input  logic ba,
  output logic ba_s,
  output logic rise,
  output logic fall
);

  logic phi2_p0, phi2_p1, phi2_p2;
  logic ba_p0, ba_p1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phi2_p0 <= 1'b0;
      phi2_p1 <= 1'b0;
      phi2_p2 <= 1'b0;
      ba_p0   <= 1'b0;
      ba_p1   <= 1'b0;
    end else begin
      phi2_p0 <= phi2;
      phi2_p1 <= phi2_p0;
      phi2_p2 <= phi2_p1;
      ba_p0   <= ba;
      ba_p1   <= ba_p0;
    end
  end

  assign ba_s = ba_p1;
  assign rise = phi2_p1 & ~phi2_p2;
  assign fall = ~phi2_p1 & phi2_p2;

endmodule

// File: rtl/c64_dma_master.sv
// C64 expansion-port DMA master: turns each req/ack toggle into one bus cycle.
// Optional macro C64_DMA_HOLD_EN keeps /DMA low between back-to-back requests.
module c64_dma_master
  import c64_bus_pkg::*;
#(
  parameter int SETTLE_PHI2  = SETTLE_PHI2_DEF,
  parameter int SAMPLE_DELAY = SAMPLE_DELAY_DEF,
  parameter int HOLD_PHI2    = HOLD_PHI2_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] dma_a,
  input  logic [7:0]  dma_d,
  input  logic        dma_rw,
  input  logic        dma_req,
  output logic        dma_ack,
  output logic [7:0]  dma_q,
  input  logic        phi2,
  input  logic        ba,
  output logic        dma_n,
  output logic [15:0] bus_a,
  output logic        bus_a_oe,
  output logic        bus_rw,
  output logic [7:0]  bus_d,
  output logic        bus_d_oe,
  input  logic [7:0]  bus_d_in
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic ba_s, rise, fall, pending, start;

  state_t            state, state_nxt;
  logic              dma_n_nxt, bus_a_oe_nxt, bus_d_oe_nxt, bus_rw_nxt, dma_ack_nxt;
  logic [15:0]       bus_a_nxt;
  logic [7:0]        bus_d_nxt, dma_q_nxt;
  logic [CNT_W-1:0]  settle_cnt, settle_nxt, sample_cnt, sample_nxt;
`ifdef C64_DMA_HOLD_EN
  logic [CNT_W-1:0]  hold_cnt, hold_nxt;
`endif

  phi2_sync u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .phi2    (phi2),
    .ba      (ba),
    .ba_s    (ba_s),
    .rise    (rise),
    .fall    (fall)
  );

  assign pending = dma_req ^ dma_ack;

  always_comb begin
    state_nxt    = state;
    dma_n_nxt    = dma_n;
    bus_a_nxt    = bus_a;
    bus_a_oe_nxt = bus_a_oe;
    bus_rw_nxt   = bus_rw;
    bus_d_nxt    = bus_d;
    bus_d_oe_nxt = bus_d_oe;
    dma_ack_nxt  = dma_ack;
    dma_q_nxt    = dma_q;
    settle_nxt   = settle_cnt;
    sample_nxt   = sample_cnt;
`ifdef C64_DMA_HOLD_EN
    hold_nxt     = hold_cnt;
`endif
    start        = 1'b0;

    case (state)
      ST_IDLE: begin
        if (pending) begin
          dma_n_nxt  = 1'b0;
          settle_nxt = '0;
          state_nxt  = ST_ARM;
        end
      end

      ST_ARM: begin
        // A fall with BA low means the VIC stole the bus again: restart settling.
        if (fall) settle_nxt = ba_s ? sat_inc(settle_cnt) : '0;
        if (rise && ba_s && settle_cnt >= CNT_W'(SETTLE_PHI2)) start = 1'b1;
      end

      ST_ACCESS: begin
        sample_nxt = sat_inc(sample_cnt);
        if (sample_cnt == CNT_W'(SAMPLE_DELAY) && bus_rw == RW_READ) dma_q_nxt = bus_d_in;
        if (fall) begin
          bus_a_oe_nxt = 1'b0;
          bus_d_oe_nxt = 1'b0;
          bus_rw_nxt   = RW_READ;
          dma_ack_nxt  = ~dma_ack;
`ifdef C64_DMA_HOLD_EN
          hold_nxt     = '0;
          state_nxt    = ST_HOLD;
`else
          state_nxt    = ST_RELEASE;
`endif
        end
      end

`ifdef C64_DMA_HOLD_EN
      ST_HOLD: begin
        if (rise && ba_s && pending) begin
          start = 1'b1;
        end else if (!ba_s) begin
          settle_nxt = '0;
          state_nxt  = ST_ARM;
        end else if (fall && !pending) begin
          hold_nxt = sat_inc(hold_cnt);
          if (sat_inc(hold_cnt) >= CNT_W'(HOLD_PHI2)) state_nxt = ST_RELEASE;
        end
      end
`endif

      ST_RELEASE: begin
        dma_n_nxt = 1'b1;
        state_nxt = ST_IDLE;
      end

      default: state_nxt = ST_IDLE;
    endcase

    // Access begins on a synchronised phi2 rise; address/data are latched here.
    if (start) begin
      state_nxt    = ST_ACCESS;
      bus_a_nxt    = dma_a;
      bus_d_nxt    = dma_d;
      bus_a_oe_nxt = 1'b1;
      bus_d_oe_nxt = (dma_rw == REQ_WRITE);
      bus_rw_nxt   = (dma_rw == REQ_WRITE) ? RW_WRITE : RW_READ;
      sample_nxt   = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      dma_n      <= 1'b1;
      bus_a      <= '0;
      bus_a_oe   <= 1'b0;
      bus_rw     <= RW_READ;
      bus_d      <= '0;
      bus_d_oe   <= 1'b0;
      dma_ack    <= 1'b0;
      dma_q      <= '0;
      settle_cnt <= '0;
      sample_cnt <= '0;
`ifdef C64_DMA_HOLD_EN
      hold_cnt   <= '0;
`endif
    end else begin
      state      <= state_nxt;
      dma_n      <= dma_n_nxt;
      bus_a      <= bus_a_nxt;
      bus_a_oe   <= bus_a_oe_nxt;
      bus_rw     <= bus_rw_nxt;
      bus_d      <= bus_d_nxt;
      bus_d_oe   <= bus_d_oe_nxt;
      dma_ack    <= dma_ack_nxt;
      dma_q      <= dma_q_nxt;
      settle_cnt <= settle_nxt;
      sample_cnt <= sample_nxt;
`ifdef C64_DMA_HOLD_EN
      hold_cnt   <= hold_nxt;
`endif
    end
  end

endmodule
